// File: rtl/fp_acc_pkg.sv
// rtl/fp_acc_pkg.sv - shared types and FP32 constants for the FP32 accumulator
// Contents: acc_state_t FSM encoding, FP32 field positions, FP_ZERO,
//           FP_MAX_FINITE, and is_zero() which tests the magnitude bits.
package fp_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } acc_state_t;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_W   = 23;

    localparam logic [31:0] FP_ZERO       = 32'h0000_0000;
    localparam logic [30:0] FP_MAX_FINITE = 31'h7F7F_FFFF;

    // +0 and -0 both count as zero; the sign bit is ignored.
    function automatic logic is_zero(input logic [31:0] v);
        return v[EXP_MSB:0] == 31'd0;
    endfunction

endpackage

// File: rtl/fp_accumulator_if.sv
// rtl/fp_accumulator_if.sv - input beat stream and result port of the FP32 accumulator
// Ports: in_valid/in_ready/in_data/in_last (beat stream),
//        out_valid/out_ready/out_sum/out_overflow/out_count (result).
// Modports: master = producer/consumer side, slave = accumulator side.
interface fp_accumulator_if #(
    parameter int COUNT_W = 16
) ();

    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_sum;
    logic               out_overflow;
    logic [COUNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_overflow, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_overflow, out_count
    );

endinterface

// File: rtl/floating_point_adder.sv
// rtl/floating_point_adder.sv - combinational FP32 adder with truncating alignment and normalisation
// Ports: a, b (FP32 operands), sum (FP32 result), overflow (result exponent >= 255).
// A hidden 1 is applied regardless of exponent, so zeros and denormals are
// not special-cased here. Callers must handle those cases themselves.
// Exact cancellation returns +0. A result exponent <= 0 flushes to +0.
module floating_point_adder
    import fp_acc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        overflow
);

    logic [7:0]  ea, eb, e_big, e_small;
    logic [23:0] ma, mb, m_big, m_small, m_sh, m_sub, m_norm;
    logic [24:0] m_add;
    logic        s_big, found, zero_res;
    logic [4:0]  lz;
    logic [9:0]  e_res;
    logic [22:0] mant_res;

    always_comb begin
        ea = a[EXP_MSB:EXP_LSB];
        eb = b[EXP_MSB:EXP_LSB];
        ma = {1'b1, a[MANT_W-1:0]};
        mb = {1'b1, b[MANT_W-1:0]};

        // Order operands by magnitude so the subtraction never goes negative.
        if ({ea, ma} >= {eb, mb}) begin
            e_big = ea; m_big = ma; e_small = eb; m_small = mb; s_big = a[SIGN_BIT];
        end else begin
            e_big = eb; m_big = mb; e_small = ea; m_small = ma; s_big = b[SIGN_BIT];
        end

        m_sh  = m_small >> (e_big - e_small);
        m_add = {1'b0, m_big} + {1'b0, m_sh};
        m_sub = m_big - m_sh;

        lz    = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && m_sub[i]) begin
                lz    = 5'(23 - i);
                found = 1'b1;
            end
        end
        m_norm = m_sub << lz;

        zero_res = 1'b0;
        if (a[SIGN_BIT] == b[SIGN_BIT]) begin
            if (m_add[24]) begin
                e_res    = {2'b00, e_big} + 10'd1;
                mant_res = m_add[23:1];
            end else begin
                e_res    = {2'b00, e_big};
                mant_res = m_add[22:0];
            end
        end else begin
            e_res    = {2'b00, e_big} - {5'd0, lz};
            mant_res = m_norm[22:0];
            if (!found || ({2'b00, e_big} <= {5'd0, lz}))
                zero_res = 1'b1;
        end

        overflow = !zero_res && (e_res >= 10'd255);
        sum      = zero_res ? FP_ZERO : {s_big, e_res[7:0], mant_res};
    end

endmodule

// File: rtl/fp_accumulator.sv
// rtl/fp_accumulator.sv - streaming FP32 sum of a last-terminated beat sequence, one beat per cycle
// Ports: clk, rst (sync, active-high),
//        bus (fp_accumulator_if.slave: beat stream in, result out).
// Optional: define FP_ACC_SATURATE_EN to clamp an overflowing sum to the
//           max finite value, keeping the adder's sign.
module fp_accumulator
    import fp_acc_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    fp_accumulator_if.slave     bus
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    acc_state_t         state;
    logic [31:0]        acc;
    logic [COUNT_W-1:0] count;
    logic               ovf;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [31:0]        add_sum;
    logic               add_ovf;
    logic [31:0]        add_result;
    logic               accept;
    logic [COUNT_W-1:0] count_inc;

    floating_point_adder u_adder (
        .a        (acc),
        .b        (bus.in_data),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

`ifdef FP_ACC_SATURATE_EN
    assign add_result = add_ovf ? {add_sum[SIGN_BIT], FP_MAX_FINITE} : add_sum;
`else
    assign add_result = add_sum;
`endif

    assign accept    = bus.in_valid && in_ready_q;
    assign count_inc = (count == COUNT_MAX) ? count : count + COUNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= FP_ZERO;
            count       <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= bus.in_data;
                        count <= COUNT_W'(1);
                        ovf   <= 1'b0;
                        if (bus.in_last) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        count <= count_inc;
                        // Zero operands bypass the adder, which would
                        // otherwise treat them as 1.0 x 2^-127.
                        if (!is_zero(bus.in_data)) begin
                            if (is_zero(acc)) begin
                                acc <= bus.in_data;
                            end else begin
                                acc <= add_result;
                                ovf <= ovf | add_ovf;
                            end
                        end
                        if (bus.in_last) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        acc         <= FP_ZERO;
                        count       <= '0;
                        ovf         <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_sum      = acc;
    assign bus.out_overflow = ovf;
    assign bus.out_count    = count;

endmodule

// File: tb/tb_fp_accumulator.sv
// tb/tb_fp_accumulator.sv - self-checking bench for fp_accumulator
module tb_fp_accumulator;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fp_accumulator_if #(.COUNT_W(CW)) bus ();

    fp_accumulator #(.COUNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Exact FP32 encoding of an integer with magnitude below 2^24.
    function automatic logic [31:0] to_fp(input int v);
        int          m;
        int          p;
        logic [31:0] mant;
        logic [7:0]  e;
        if (v == 0) return 32'h0;
        m = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 31; i++)
            if ((m >> i) != 0) p = i;
        mant = 32'(m) << (23 - p);
        e    = 8'(127 + p);
        return {(v < 0), e, mant[22:0]};
    endfunction

    // Present one beat and hold it until the bench sees in_ready, then one
    // more cycle so the accepting edge has passed. Called at a negedge.
    task automatic send(input logic [31:0] d, input logic last);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("send_timeout", 32'd1, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_seq(input logic [31:0] q[$]);
        foreach (q[i]) send(q[i], i == q.size() - 1);
    endtask

    task automatic expect_result(input string tag, input logic [31:0] sum,
                                 input int cnt, input logic ovf, input int hold);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_inrdy"}, 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_inrdy"}, 32'(bus.in_ready), 32'd0);
            chk({tag, "_hold_sum"}, bus.out_sum, sum);
        end
        chk({tag, "_sum"}, bus.out_sum, sum);
        chk({tag, "_count"}, 32'(bus.out_count), 32'(cnt));
        chk({tag, "_ovf"}, 32'(bus.out_overflow), 32'(ovf));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_idle_inrdy"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] q[$];
        int          vals[$];
        int          total;
        logic [31:0] exp_ovf_sum;

        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_inrdy", 32'(bus.in_ready), 32'd1);
        chk("rst_sum", bus.out_sum, 32'h0);
        chk("rst_ovf", 32'(bus.out_overflow), 32'd0);
        chk("rst_count", 32'(bus.out_count), 32'd0);

        send_seq('{32'h3F800000, 32'h40000000});
        expect_result("one_plus_two", 32'h40400000, 2, 1'b0, 0);

        // Result handshake and a new beat in the same DONE cycle.
        send_seq('{32'h40400000, 32'hBF800000});
        chk("three_minus_one", bus.out_sum, 32'h40000000);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h40A00000;
        bus.in_last   = 1'b1;
        chk("overlap_inrdy", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("overlap_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("overlap_idle_inrdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        expect_result("single", 32'h40A00000, 1, 1'b0, 0);

        send_seq('{32'h00000000, 32'h3F800000, 32'h80000000});
        expect_result("zeros", 32'h3F800000, 3, 1'b0, 0);

`ifdef FP_ACC_SATURATE_EN
        exp_ovf_sum = 32'h7F7FFFFF;
`else
        exp_ovf_sum = 32'h7FFFFFFF;
`endif
        send_seq('{32'h7F7FFFFF, 32'h7F7FFFFF});
        expect_result("overflow", exp_ovf_sum, 2, 1'b1, 0);

        send_seq('{32'h3F800000, 32'h3F800000});
        expect_result("hold", 32'h40000000, 2, 1'b0, 5);

        // 16 beats of 1.0: the sum keeps going, the count stops at its max.
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(32'h3F800000);
        send_seq(q);
        expect_result("count_sat", 32'h41800000, CMAX, 1'b0, 0);

        // Reset mid-sequence discards the partial sum.
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_inrdy", 32'(bus.in_ready), 32'd1);
        chk("midrst_count", 32'(bus.out_count), 32'd0);
        chk("midrst_sum", bus.out_sum, 32'h0);
        send_seq('{32'h3F800000});
        expect_result("after_rst", 32'h3F800000, 1, 1'b0, 0);

        // Random integer-valued sequences: every partial sum is exact in
        // FP32, so the reference is the integer sum re-encoded.
        for (int s = 0; s < 30; s++) begin
            int len;
            len   = $urandom_range(1, 20);
            vals  = {};
            q     = {};
            total = 0;
            for (int i = 0; i < len; i++) begin
                int v;
                if ($urandom_range(0, 4) == 0) v = 0;
                else begin
                    v = $urandom_range(1, 1000);
                    if ($urandom_range(0, 1) == 1) v = -v;
                end
                vals.push_back(v);
                q.push_back(to_fp(v));
                total += v;
            end
            send_seq(q);
            expect_result($sformatf("rand%0d", s), to_fp(total),
                          (len > CMAX) ? CMAX : len, 1'b0, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
